lcd_bus_sequencer: RTL and testbench
====================================

Name: lcd_bus_sequencer

Overview:
- Takes 24-bit LCD command/data words from the SPI receive path: one-cycle store strobe plus the latched word.
- Buffers the words in a small FIFO.
- Replays each word onto the LCD's 16-bit 8080-style parallel bus with programmable setup, write-strobe and hold timing.
- Sits between the SPI word receiver and the panel pins. It is the sole driver of LCD_DB, LCD_RS, LCD_WR_N, LCD_CS_N and LCD_RST_N.

Parameters:
- FIFO_DEPTH, 4, word buffer entries; power of two, 2..16.
- T_SETUP, 2, CLK cycles CS_N/RS/DB are valid before WR_N falls; 1..255.
- T_WR, 3, CLK cycles WR_N is held low; 1..255.
- T_HOLD, 2, CLK cycles DB/RS/CS_N are held after WR_N rises; 1..255.

Ports:
- CLK  in  1  system clock.
- RESETN  in  1  asynchronous active-low reset.
- WORD_VALID  in  1  one-cycle strobe; WORD is valid this cycle.
- WORD  in  24  [15:0] bus data; [16] RS; [17] RST_N level; [18] NOWR; [19] DELAY (optional feature only); [23:20] ignored.
- LCD_DB  out  16  parallel data bus.
- LCD_RS  out  1  register select: 0 = command, 1 = data.
- LCD_WR_N  out  1  write strobe, active low.
- LCD_CS_N  out  1  chip select, active low.
- LCD_RST_N  out  1  panel reset, active low.
- BUSY  out  1  FIFO non-empty or FSM not in IDLE.
- OVERFLOW  out  1  sticky: a word was dropped.

Behaviour:
- Reset (async, RESETN=0): LCD_DB=0, LCD_RS=0, LCD_WR_N=1, LCD_CS_N=1, LCD_RST_N=0, BUSY=0, OVERFLOW=0, FIFO emptied, FSM=IDLE. Applies immediately, including mid-strobe; the aborted word is lost.
- Push: WORD_VALID=1 writes WORD into the FIFO at that edge.
  - If the FIFO is full and no pop occurs in the same cycle, the word is dropped and OVERFLOW is set to 1 until reset.
  - Push and pop in the same cycle on a full FIFO: the push is accepted.
- FSM states: IDLE, SETUP, STROBE, HOLD (plus WAIT when the optional feature is compiled in). Counter is 8 bits.
- IDLE:
  - LCD_CS_N=1, LCD_WR_N=1.
  - If the FIFO is non-empty, pop the head word.
  - NOWR=1: only LCD_RST_N <= WORD[17] on the next edge; stay in IDLE.
  - NOWR=0: latch DB=WORD[15:0], RS=WORD[16], LCD_RST_N=WORD[17], drive LCD_CS_N=0; go to SETUP.
- SETUP: hold T_SETUP cycles -> STROBE.
- STROBE: LCD_WR_N=0 for T_WR cycles -> HOLD.
- HOLD: LCD_WR_N=1, DB/RS/CS_N unchanged, for T_HOLD cycles -> IDLE.
- LCD_CS_N returns to 1 for at least one cycle between writes.
- Latency, for WORD_VALID at edge N:
  - Pop at N+1.
  - LCD_CS_N low from N+2.
  - LCD_WR_N low from N+2+T_SETUP for exactly T_WR cycles.
- Throughput: one write per 1+T_SETUP+T_WR+T_HOLD cycles (8 at defaults). A NOWR word costs 1 cycle.
- LCD_DB and LCD_RS keep their last value in IDLE; they do not return to 0.
- WORD[23:20] is ignored. WORD[19] is ignored when the optional feature is excluded.

Optional Feature:
- Macro: LCD_SEQ_DELAY_EN.
- Defined:
  - A popped word with [19]=1 is a delay command: no bus activity, CS_N stays 1.
  - FSM enters WAIT for WORD[15:0]*64 CLK cycles, then returns to IDLE. A value of 0 means 1 cycle.
  - WAIT counter is 22 bits. BUSY=1 during WAIT.
- Undefined: bit 19 is ignored, no WAIT state, and the counter stays 8 bits.

Decomposition:
- Package lcd_seq_pkg:
  - WORD field bit positions (DB_LSB/MSB, RS_BIT, RST_BIT, NOWR_BIT, DELAY_BIT).
  - FSM state enum.
  - DELAY_SHIFT=6.
- Sub-module lcd_word_fifo:
  - Synchronous FIFO, 24-bit wide, FIFO_DEPTH entries.
  - Signals: push, pop, full, empty, dout.
  - Async active-low reset.

Test Plan:
- Reset state -> all outputs at reset values; LCD_RST_N=0.
- Single word 0x030ABC at cycle N -> CS_N low at N+2, RS=1, RST_N=1, DB=0x0ABC; WR_N low at cycles N+4..N+6; CS_N high at N+9.
- Word with NOWR=1, bit17=1 (0x060000) -> LCD_RST_N rises two cycles after the strobe; WR_N and CS_N never toggle.
- 6 strobes on back-to-back cycles, FIFO_DEPTH=4 -> the first 5 are written to the bus in order (one pops while the rest queue), the 6th is dropped, OVERFLOW=1 and remains 1 until reset.
- RESETN pulsed low during STROBE -> WR_N=1 and CS_N=1 immediately; FIFO empty; no further writes after release.
- With LCD_SEQ_DELAY_EN, delay word 0x080002 followed by a data word -> the second CS_N fall occurs 128 cycles later than without the delay word.

Source files
------------

// File: rtl/lcd_seq_pkg.sv
// Shared field positions, FSM state encoding and counter sizing for the LCD bus sequencer.
// The LCD_SEQ_DELAY_EN macro adds the WAIT state and widens the cycle counter.
package lcd_seq_pkg;

  localparam int WORD_W      = 24;
  localparam int DB_LSB      = 0;
  localparam int DB_MSB      = 15;
  localparam int RS_BIT      = 16;
  localparam int RST_BIT     = 17;
  localparam int NOWR_BIT    = 18;
  localparam int DELAY_BIT   = 19;
  localparam int DELAY_SHIFT = 6;

`ifdef LCD_SEQ_DELAY_EN
  localparam int CNT_W = 22;
  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_WAIT
  } state_e;
`else
  localparam int CNT_W = 8;
  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_e;
`endif

endpackage

// File: rtl/lcd_word_fifo.sv
// Synchronous word FIFO with wrap-bit pointers; a push is accepted on a full FIFO
// only when a pop happens in the same cycle.
module lcd_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 24
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] dout_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage carries no reset; pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/lcd_bus_sequencer.sv
// Buffers SPI-received 24-bit words and replays them as timed 8080-style 16-bit bus writes.
// Define LCD_SEQ_DELAY_EN to honour delay-command words (WAIT state, 22-bit counter).
module lcd_bus_sequencer
  import lcd_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int T_SETUP    = 2,
  parameter int T_WR       = 3,
  parameter int T_HOLD     = 2
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              WORD_VALID,
  input  logic [WORD_W-1:0] WORD,
  output logic [15:0]       LCD_DB,
  output logic              LCD_RS,
  output logic              LCD_WR_N,
  output logic              LCD_CS_N,
  output logic              LCD_RST_N,
  output logic              BUSY,
  output logic              OVERFLOW
);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] WR_LD    = CNT_W'(T_WR - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [15:0]       db_q, db_d;
  logic              rs_q, rs_d;
  logic              wr_n_q, wr_n_d;
  logic              cs_n_q, cs_n_d;
  logic              rst_n_q, rst_n_d;
  logic              ovf_q;
  logic              fifo_pop, fifo_full, fifo_empty;
  logic [WORD_W-1:0] head;
  logic              unused_bits;

  lcd_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RESETN),
    .push_i  (WORD_VALID),
    .din_i   (WORD),
    .pop_i   (fifo_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .dout_o  (head)
  );

  assign unused_bits = ^{head[WORD_W-1:20], head[DELAY_BIT]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    db_d     = db_q;
    rs_d     = rs_q;
    wr_n_d   = wr_n_q;
    cs_n_d   = cs_n_q;
    rst_n_d  = rst_n_q;
    fifo_pop = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
`ifdef LCD_SEQ_DELAY_EN
          if (head[DELAY_BIT]) begin
            state_d = S_WAIT;
            // WAIT lasts value*64 cycles; a zero value still costs one cycle.
            cnt_d   = (head[DB_MSB:DB_LSB] == '0) ? '0 :
                      (CNT_W'(head[DB_MSB:DB_LSB]) << DELAY_SHIFT) - CNT_ONE;
          end else
`endif
          if (head[NOWR_BIT]) begin
            rst_n_d = head[RST_BIT];
          end else begin
            db_d    = head[DB_MSB:DB_LSB];
            rs_d    = head[RS_BIT];
            rst_n_d = head[RST_BIT];
            cs_n_d  = 1'b0;
            cnt_d   = SETUP_LD;
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          wr_n_d  = 1'b0;
          cnt_d   = WR_LD;
          state_d = S_STROBE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          wr_n_d  = 1'b1;
          cnt_d   = HOLD_LD;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          cs_n_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
`ifdef LCD_SEQ_DELAY_EN
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
`endif
      default: begin
        wr_n_d  = 1'b1;
        cs_n_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      db_q    <= '0;
      rs_q    <= 1'b0;
      wr_n_q  <= 1'b1;
      cs_n_q  <= 1'b1;
      rst_n_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      rs_q    <= rs_d;
      wr_n_q  <= wr_n_d;
      cs_n_q  <= cs_n_d;
      rst_n_q <= rst_n_d;
      if (WORD_VALID && fifo_full && !fifo_pop) ovf_q <= 1'b1;
    end
  end

  assign LCD_DB    = db_q;
  assign LCD_RS    = rs_q;
  assign LCD_WR_N  = wr_n_q;
  assign LCD_CS_N  = cs_n_q;
  assign LCD_RST_N = rst_n_q;
  assign BUSY      = !fifo_empty || (state_q != S_IDLE);
  assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_lcd_bus_sequencer.sv
// Directed bench for lcd_bus_sequencer: timing, NOWR, overflow, async reset and
// (with LCD_SEQ_DELAY_EN) delay words; bus writes are checked against a scoreboard queue.
module tb_lcd_bus_sequencer;

  localparam int T_WR = 3;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        WORD_VALID = 1'b0;
  logic [23:0] WORD = '0;
  logic [15:0] LCD_DB;
  logic        LCD_RS, LCD_WR_N, LCD_CS_N, LCD_RST_N, BUSY, OVERFLOW;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int writes = 0;
  logic [16:0] exp_q[$];

  lcd_bus_sequencer #(
    .FIFO_DEPTH (4),
    .T_SETUP    (2),
    .T_WR       (T_WR),
    .T_HOLD     (2)
  ) dut (
    .CLK        (CLK),
    .RESETN     (RESETN),
    .WORD_VALID (WORD_VALID),
    .WORD       (WORD),
    .LCD_DB     (LCD_DB),
    .LCD_RS     (LCD_RS),
    .LCD_WR_N   (LCD_WR_N),
    .LCD_CS_N   (LCD_CS_N),
    .LCD_RST_N  (LCD_RST_N),
    .BUSY       (BUSY),
    .OVERFLOW   (OVERFLOW)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one strobe; n returns the cycle count of the capturing edge.
  task automatic strobe(input logic [23:0] w, output int n);
    @(posedge CLK);
    #1 WORD_VALID = 1'b1;
    WORD = w;
    @(posedge CLK);
    #1 n = cyc;
    WORD_VALID = 1'b0;
  endtask

  // Bus monitor: every WR_N fall must match the oldest expected word.
  logic        prev_wr = 1'b1;
  int          wr_len = 0;
  logic [16:0] sb_word;
  always @(negedge CLK) begin
    if (!RESETN) begin
      prev_wr = 1'b1;
      wr_len  = 0;
    end else begin
      if (prev_wr && !LCD_WR_N) begin
        writes++;
        chk("cs_low_at_wr", LCD_CS_N, 1'b0);
        chk("sb_pending", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          sb_word = exp_q.pop_front();
          chk("bus_word", {LCD_RS, LCD_DB}, sb_word);
        end
      end
      if (!LCD_WR_N) wr_len++;
      else if (wr_len != 0) begin
        chk("wr_width", wr_len, T_WR);
        wr_len = 0;
      end
      prev_wr = LCD_WR_N;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int w0;
    int k;
    logic [15:0] d;

    // Reset values
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_db", LCD_DB, 16'h0);
    chk("rst_rs", LCD_RS, 1'b0);
    chk("rst_wr_n", LCD_WR_N, 1'b1);
    chk("rst_cs_n", LCD_CS_N, 1'b1);
    chk("rst_rst_n", LCD_RST_N, 1'b0);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_ovf", OVERFLOW, 1'b0);
    @(posedge CLK);
    #1 RESETN = 1'b1;

    // NOWR word only moves the panel reset line
    strobe(24'h060000, n);
    for (int rel = 1; rel <= 4; rel++) begin
      @(negedge CLK);
      chk($sformatf("nowr_rst_n_r%0d", rel), LCD_RST_N, (rel >= 2) ? 1'b1 : 1'b0);
      chk($sformatf("nowr_wr_n_r%0d", rel), LCD_WR_N, 1'b1);
      chk($sformatf("nowr_cs_n_r%0d", rel), LCD_CS_N, 1'b1);
    end
    chk("nowr_busy_done", BUSY, 1'b0);

    // Single data word: CS_N low N+2..N+8, WR_N low N+4..N+6
    exp_q.push_back({1'b1, 16'h0ABC});
    strobe(24'h030ABC, n);
    for (int rel = 1; rel <= 9; rel++) begin
      @(negedge CLK);
      chk($sformatf("single_cs_n_r%0d", rel), LCD_CS_N, (rel >= 2 && rel <= 8) ? 1'b0 : 1'b1);
      chk($sformatf("single_wr_n_r%0d", rel), LCD_WR_N, (rel >= 4 && rel <= 6) ? 1'b0 : 1'b1);
      if (rel == 2) begin
        chk("single_db", LCD_DB, 16'h0ABC);
        chk("single_rs", LCD_RS, 1'b1);
        chk("single_rst_n", LCD_RST_N, 1'b1);
      end
    end
    repeat (2) @(negedge CLK);
    chk("single_db_kept", LCD_DB, 16'h0ABC);
    chk("single_sb_empty", exp_q.size(), 0);

    // Six back-to-back strobes into a 4-deep FIFO: five written, sixth dropped
    chk("ovf_before", OVERFLOW, 1'b0);
    w0 = writes;
    for (int i = 0; i < 6; i++) begin
      d = 16'h1111 * 16'(i + 1);
      @(posedge CLK);
      #1 WORD_VALID = 1'b1;
      WORD = {4'h0, 1'b0, 1'b0, 1'b1, 1'(i % 2), d};
      if (i < 5) exp_q.push_back({1'(i % 2), d});
    end
    @(posedge CLK);
    #1 WORD_VALID = 1'b0;
    k = 0;
    while ((exp_q.size() != 0 || BUSY) && k < 120) begin
      @(negedge CLK);
      k++;
    end
    chk("ovf_drain_in_time", k < 120, 1'b1);
    repeat (10) @(negedge CLK);
    chk("ovf_write_count", writes - w0, 5);
    chk("ovf_sb_empty", exp_q.size(), 0);
    chk("ovf_set", OVERFLOW, 1'b1);
    chk("ovf_busy_idle", BUSY, 1'b0);

`ifdef LCD_SEQ_DELAY_EN
    // Delay word (2*64) ahead of a data word pushed the next cycle
    exp_q.push_back({1'b0, 16'h0055});
    @(posedge CLK);
    #1 WORD_VALID = 1'b1;
    WORD = 24'h080002;
    @(posedge CLK);
    #1 WORD = 24'h020055;
    @(posedge CLK);
    #1 WORD_VALID = 1'b0;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
      if (k == 2) chk("delay_cs_n_quiet", LCD_CS_N, 1'b1);
      if (k == 60) chk("delay_busy", BUSY, 1'b1);
    end while (LCD_CS_N && k < 400);
    chk("delay_cs_fall_rel", k, 2 + 128);
    repeat (12) @(negedge CLK);
    chk("delay_sb_empty", exp_q.size(), 0);
`endif

    // Async reset in the middle of a write strobe
    exp_q.push_back({1'b1, 16'h1234});
    strobe(24'h031234, n);
    strobe(24'h035678, n);
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (LCD_WR_N && k < 40);
    chk("arst_wr_low_seen", LCD_WR_N, 1'b0);
    @(posedge CLK);
    #1 RESETN = 1'b0;
    #1;
    chk("arst_wr_n", LCD_WR_N, 1'b1);
    chk("arst_cs_n", LCD_CS_N, 1'b1);
    chk("arst_busy", BUSY, 1'b0);
    chk("arst_ovf", OVERFLOW, 1'b0);
    chk("arst_rst_n", LCD_RST_N, 1'b0);
    chk("arst_db", LCD_DB, 16'h0);
    repeat (2) @(negedge CLK);
    @(posedge CLK);
    #1 RESETN = 1'b1;
    w0 = writes;
    repeat (30) @(negedge CLK);
    chk("arst_no_writes", writes - w0, 0);
    chk("arst_cs_n_idle", LCD_CS_N, 1'b1);
    chk("arst_busy_idle", BUSY, 1'b0);
    chk("arst_sb_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
